axil_up_reg_responder: RTL
==========================

// Module: axil_up_reg_responder
// PURPOSE
//  AXI-Lite responder at the user-project end of the FSIC AXI-Lite config path.
//  It receives the per-project AW/W/AR/R request stream from the upstream AXI-Lite
//  fan-out and answers it with a small byte-strobed register bank.
//  Reg0 drives ctrl_out. Reg1 is read-only and returns status_in. All other registers are RW scratch.
//  The interface has no B channel: a write completes on its AW and W handshakes.
// PARAMETERS
//  pADDR_WIDTH  12  byte-address width of awaddr/araddr
//  pDATA_WIDTH  32  data width; wstrb width is pDATA_WIDTH/8
//  pNUM_REGS    16  number of 32-bit registers (power of 2, >=2), word-addressed from 0x000
// PORTS
//  axi_clk      in   1    clock
//  axi_reset_n  in   1    asynchronous reset, active-low
//  awvalid      in   1    write-address valid
//  awaddr       in   12   write byte address
//  awready      out  1    write-address ready
//  wvalid       in   1    write-data valid
//  wdata        in   32   write data
//  wstrb        in   4    byte-lane write enables
//  wready       out  1    write-data ready
//  arvalid      in   1    read-address valid
//  araddr       in   12   read byte address
//  arready      out  1    read-address ready
//  rvalid       out  1    read-data valid
//  rdata        out  32   read data
//  rready       in   1    read-data ready
//  status_in    in   32   live status word, returned when reg1 is read
//  ctrl_out     out  32   registered copy of reg0
// BEHAVIOUR
//  Reset (async, axi_reset_n=0):
//   - all registers, rdata, rvalid and ctrl_out = 0
//   - aw_held = w_held = 0, read FSM = R_IDLE
//   - awready, wready, arready = 1 from the first cycle after reset is released
//  Decode:
//   - word index = addr[log2(pNUM_REGS)+1:2]
//   - any address >= pNUM_REGS*4 is out of range: writes are dropped, reads return 0
//   - addr[1:0] is ignored
//  Write path (AW and W captured independently, in either order):
//   - awready = !aw_held; an AW handshake latches awaddr and sets aw_held
//   - wready = !w_held; a W handshake latches wdata/wstrb and sets w_held
//   - commit cycle = any cycle with aw_held && w_held
//     - apply byte lane i where wstrb[i]=1
//     - clear both flags
//     - awready = wready = 0 during the commit cycle
//   - AW and W handshaking together in cycle N: register updated at the edge ending cycle N+1
//   - writes to reg1 are dropped; wstrb=0 commits with no change
//   - ctrl_out follows reg0 with no extra delay
//   - a second AW while aw_held=1 is stalled (awready=0), never overwritten; same rule for W
//  Read FSM:
//   - R_IDLE: arready=1, rvalid=0. AR handshake -> rdata <= selected reg (status_in for reg1, 0 if out of range), rvalid <= 1, go R_DATA
//   - R_DATA: arready=0; rvalid and rdata held stable until rready=1, then rvalid <= 0, return to R_IDLE
//   - read latency: AR handshake in cycle N -> rvalid=1 in cycle N+1
//   - back-to-back: after the R handshake, the next AR can be accepted in the following cycle
//   - rdata keeps its last value when rvalid=0
//  Simultaneous events:
//   - read and write run fully in parallel
//   - AR handshake on the same edge as a commit to the same register returns the pre-write value
//  Reset mid-operation:
//   - held AW/W and a pending rvalid are discarded
//   - the register bank returns to 0
//   - no partial write may be applied
// TESTING
//  1. Release reset -> awready=wready=arready=1, rvalid=0, ctrl_out=0; read 0x008 -> rdata=0x00000000.
//  2. AW(0x000) and W(0xA5A5_1234, wstrb=4'hF) in the same cycle -> ctrl_out=0xA5A51234 two edges later; read 0x000 returns it.
//  3. W(0xFFFF_FFFF, wstrb=4'b0101) three cycles before AW(0x008) -> wready=0 while W is held; read 0x008 = 0x00FF00FF.
//  4. status_in=0xDEAD_BEEF, write 0 to 0x004, read 0x004 -> 0xDEADBEEF; read 0x040 with 16 regs -> 0x00000000.
//  5. Read with rready held low 5 cycles -> rvalid and rdata stable, arready=0 throughout; next AR accepted the cycle after rready.
//  6. axi_reset_n pulsed low while AW is held and rvalid=1 -> all outputs return to reset values; no register changes after release.

Source files
------------

// File: rtl/axil_up_reg_responder_if.sv
// AXI-Lite AW/W/AR/R bundle between the upstream fan-out and a user-project responder (no B channel).
interface axil_up_reg_responder_if #(
  parameter int unsigned pADDR_WIDTH = 12,
  parameter int unsigned pDATA_WIDTH = 32
);
  localparam int unsigned STRB_W = pDATA_WIDTH / 8;

  logic                   awvalid;
  logic [pADDR_WIDTH-1:0] awaddr;
  logic                   awready;
  logic                   wvalid;
  logic [pDATA_WIDTH-1:0] wdata;
  logic [STRB_W-1:0]      wstrb;
  logic                   wready;
  logic                   arvalid;
  logic [pADDR_WIDTH-1:0] araddr;
  logic                   arready;
  logic                   rvalid;
  logic [pDATA_WIDTH-1:0] rdata;
  logic                   rready;

  modport master (
    output awvalid, awaddr, wvalid, wdata, wstrb, arvalid, araddr, rready,
    input  awready, wready, arready, rvalid, rdata
  );

  modport slave (
    input  awvalid, awaddr, wvalid, wdata, wstrb, arvalid, araddr, rready,
    output awready, wready, arready, rvalid, rdata
  );
endinterface

// File: rtl/axil_up_reg_responder.sv
// User-project AXI-Lite responder: byte-strobed register bank, reg0 -> ctrl_out, reg1 = status_in.
module axil_up_reg_responder #(
  parameter int unsigned pADDR_WIDTH = 12,
  parameter int unsigned pDATA_WIDTH = 32,
  parameter int unsigned pNUM_REGS   = 16
) (
  input  logic                   axi_clk,
  input  logic                   axi_reset_n,
  axil_up_reg_responder_if.slave bus,
  input  logic [pDATA_WIDTH-1:0] status_in,
  output logic [pDATA_WIDTH-1:0] ctrl_out
);
  localparam int unsigned IDX_W   = $clog2(pNUM_REGS);
  localparam int unsigned STRB_W  = pDATA_WIDTH / 8;
  localparam int unsigned WADDR_W = pADDR_WIDTH - 2;

  localparam logic [0:0] R_IDLE = 1'b0;
  localparam logic [0:0] R_DATA = 1'b1;

  logic                   aw_held;
  logic                   w_held;
  logic [WADDR_W-1:0]     aw_waddr;
  logic [pDATA_WIDTH-1:0] w_data;
  logic [STRB_W-1:0]      w_strb;
  logic                   commit;
  logic [IDX_W-1:0]       aw_idx;
  logic                   aw_in_range;

  logic [pDATA_WIDTH-1:0] regs [pNUM_REGS];

  logic [0:0]             state_q;
  logic [0:0]             state_d;
  logic                   rvalid_q;
  logic                   rvalid_d;
  logic [pDATA_WIDTH-1:0] rdata_q;
  logic [pDATA_WIDTH-1:0] rdata_d;
  logic [WADDR_W-1:0]     ar_waddr;
  logic [IDX_W-1:0]       ar_idx;
  logic                   ar_in_range;
  logic [pDATA_WIDTH-1:0] rd_word;

  // Byte offset bits are don't-care; fold them away so they are visibly consumed.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{bus.awaddr[1:0], bus.araddr[1:0]};

  // Word-address decode: everything above the index bits must be zero to hit the bank.
  assign commit      = aw_held & w_held;
  assign aw_idx      = aw_waddr[IDX_W-1:0];
  assign aw_in_range = (aw_waddr >> IDX_W) == '0;
  assign ar_waddr    = bus.araddr[pADDR_WIDTH-1:2];
  assign ar_idx      = ar_waddr[IDX_W-1:0];
  assign ar_in_range = (ar_waddr >> IDX_W) == '0;

  assign bus.awready = ~aw_held;
  assign bus.wready  = ~w_held;
  assign bus.arready = (state_q == R_IDLE);
  assign bus.rvalid  = rvalid_q;
  assign bus.rdata   = rdata_q;
  assign ctrl_out    = regs[0];

  // Capture AW and W independently; both flags clear together on the commit cycle.
  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      aw_waddr <= '0;
      w_data   <= '0;
      w_strb   <= '0;
    end else if (commit) begin
      aw_held <= 1'b0;
      w_held  <= 1'b0;
    end else begin
      if (bus.awvalid && !aw_held) begin
        aw_held  <= 1'b1;
        aw_waddr <= bus.awaddr[pADDR_WIDTH-1:2];
      end
      if (bus.wvalid && !w_held) begin
        w_held <= 1'b1;
        w_data <= bus.wdata;
        w_strb <= bus.wstrb;
      end
    end
  end

  // Register bank: byte-lane update on commit; reg1 and out-of-range targets are dropped.
  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      for (int i = 0; i < int'(pNUM_REGS); i++) regs[i] <= '0;
    end else if (commit && aw_in_range && (aw_idx != IDX_W'(1))) begin
      for (int b = 0; b < int'(STRB_W); b++) begin
        if (w_strb[b]) regs[aw_idx][8*b +: 8] <= w_data[8*b +: 8];
      end
    end
  end

  // Read mux: status word for reg1, zero outside the bank.
  always_comb begin
    rd_word = '0;
    if (ar_in_range) begin
      rd_word = (ar_idx == IDX_W'(1)) ? status_in : regs[ar_idx];
    end
  end

  // Read FSM state and R channel registers.
  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      state_q  <= R_IDLE;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

  // Read FSM next-state: accept AR in idle, hold R until rready.
  always_comb begin
    state_d  = state_q;
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    case (state_q)
      R_IDLE: begin
        if (bus.arvalid) begin
          rdata_d  = rd_word;
          rvalid_d = 1'b1;
          state_d  = R_DATA;
        end
      end
      R_DATA: begin
        if (bus.rready) begin
          rvalid_d = 1'b0;
          state_d  = R_IDLE;
        end
      end
      default: begin
        rvalid_d = 1'b0;
        state_d  = R_IDLE;
      end
    endcase
  end
endmodule
